// File: rtl/find_best_hop.sv
// find_best_hop: scans the neighbour table in shared memory and reports the
// highest-Q neighbour (nexthop) and the highest-Q in-cluster sink (nextsinks).
// Every memory read takes two cycles: the address is set on one edge and the
// data is captured two edges later, on the edge that also sets the next address.
module find_best_hop #(
    parameter logic [10:0] COUNT_ADDR    = 11'h010,
    parameter logic [10:0] ID_BASE       = 11'h020,
    parameter logic [10:0] Q_BASE        = 11'h040,
    parameter logic [10:0] SINK_BASE     = 11'h060,
    parameter int          MAX_NEIGHBORS = 16,
    parameter logic [15:0] NONE_ID       = 16'd65
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        en,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic [10:0] address,
    output logic [15:0] nexthop,
    output logic [15:0] nextsinks,
    output logic        done
);

    typedef enum logic [2:0] {
        S_WAIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_CNT     = 3'd2,
        S_RD_ID   = 3'd3,
        S_RD_Q    = 3'd4,
        S_RD_SINK = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [4:0]  MAX_N    = 5'(MAX_NEIGHBORS);
    localparam logic [15:0] MAX_N_16 = 16'(MAX_NEIGHBORS);

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [10:0] address_q, address_d;
    logic [15:0] nexthop_q, nexthop_d;
    logic [15:0] nextsinks_q, nextsinks_d;
    logic [15:0] bestQ_q, bestQ_d;
    logic [15:0] bestSinkQ_q, bestSinkQ_d;
    logic [15:0] id_q, id_d;
    logic [15:0] qVal_q, qVal_d;
    logic [4:0]  index_q, index_d;
    logic [4:0]  count_q, count_d;
    logic        done_q, done_d;

    logic [4:0]  countClamped;
    logic [4:0]  indexNext;

    assign countClamped = (data_in > MAX_N_16) ? MAX_N : data_in[4:0];
    assign indexNext    = index_q + 5'd1;

    assign address   = address_q;
    assign nexthop   = nexthop_q;
    assign nextsinks = nextsinks_q;
    assign done      = done_q;

    // State register; reset parks the scanner in WAIT so a new scan needs en first.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; read states advance only on their capture (second) cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:    if (en)      state_d = S_IDLE;
            S_IDLE:    if (start)   state_d = S_CNT;
            S_CNT:     if (phase_q) state_d = (countClamped == 5'd0) ? S_DONE : S_RD_ID;
            S_RD_ID:   if (phase_q) state_d = S_RD_Q;
            S_RD_Q:    if (phase_q) state_d = S_RD_SINK;
            S_RD_SINK: if (phase_q) state_d = (indexNext == count_q) ? S_DONE : S_RD_ID;
            S_DONE:    state_d = S_WAIT;
            default:   state_d = S_WAIT;
        endcase
    end

    // Datapath next values: address sequencing, field capture and best-Q evaluation.
    always_comb begin
        phase_d     = 1'b0;
        address_d   = address_q;
        nexthop_d   = nexthop_q;
        nextsinks_d = nextsinks_q;
        bestQ_d     = bestQ_q;
        bestSinkQ_d = bestSinkQ_q;
        id_d        = id_q;
        qVal_d      = qVal_q;
        index_d     = index_q;
        count_d     = count_q;
        done_d      = done_q;
        case (state_q)
            S_WAIT: begin
                if (en) begin
                    done_d      = 1'b0;
                    nexthop_d   = NONE_ID;
                    nextsinks_d = NONE_ID;
                    bestQ_d     = 16'd0;
                    bestSinkQ_d = 16'd0;
                    index_d     = 5'd0;
                    address_d   = 11'd0;
                end
            end
            S_IDLE: begin
                if (start) begin
                    address_d = COUNT_ADDR;
                end
            end
            S_CNT: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    count_d = countClamped;
                    if (countClamped != 5'd0) begin
                        address_d = ID_BASE + {6'd0, index_q};
                    end
                end
            end
            S_RD_ID: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    id_d      = data_in;
                    address_d = Q_BASE + {6'd0, index_q};
                end
            end
            S_RD_Q: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    qVal_d    = data_in;
                    address_d = SINK_BASE + {6'd0, index_q};
                end
            end
            S_RD_SINK: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    // An ID equal to NONE_ID is never accepted, so holding NONE_ID means "nothing held yet".
                    if (id_q != NONE_ID) begin
                        if ((nexthop_q == NONE_ID) || (qVal_q > bestQ_q)) begin
                            nexthop_d = id_q;
                            bestQ_d   = qVal_q;
                        end
                        if ((data_in != 16'd0) &&
                            ((nextsinks_q == NONE_ID) || (qVal_q > bestSinkQ_q))) begin
                            nextsinks_d = id_q;
                            bestSinkQ_d = qVal_q;
                        end
                    end
                    index_d = indexNext;
                    if (indexNext != count_q) begin
                        address_d = ID_BASE + {6'd0, indexNext};
                    end
                end
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                phase_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; reset clears everything so an aborted scan leaves no partial result.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            phase_q     <= 1'b0;
            address_q   <= 11'd0;
            nexthop_q   <= NONE_ID;
            nextsinks_q <= NONE_ID;
            bestQ_q     <= 16'd0;
            bestSinkQ_q <= 16'd0;
            id_q        <= 16'd0;
            qVal_q      <= 16'd0;
            index_q     <= 5'd0;
            count_q     <= 5'd0;
            done_q      <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            address_q   <= address_d;
            nexthop_q   <= nexthop_d;
            nextsinks_q <= nextsinks_d;
            bestQ_q     <= bestQ_d;
            bestSinkQ_q <= bestSinkQ_d;
            id_q        <= id_d;
            qVal_q      <= qVal_d;
            index_q     <= index_d;
            count_q     <= count_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_find_best_hop.sv
// tb_find_best_hop: directed table-driven bench for find_best_hop with a
// combinational memory model and hand-written reset/handshake sequences.
module tb_find_best_hop;

    localparam logic [10:0] COUNT_ADDR = 11'h010;
    localparam logic [10:0] ID_BASE    = 11'h020;
    localparam logic [10:0] Q_BASE     = 11'h040;
    localparam logic [10:0] SINK_BASE  = 11'h060;
    localparam int          NUM_VECS   = 8;

    typedef struct {
        logic [15:0]        count;
        logic [15:0][15:0]  ids;
        logic [15:0][15:0]  qs;
        logic [15:0][15:0]  flags;
        logic [15:0]        expNext;
        logic [15:0]        expSink;
        int                 expLat;
        logic [10:0]        expAddr;
    } vec_t;

    logic        clock;
    logic        rst;
    logic        en;
    logic        start;
    logic [15:0] data_in;
    logic [10:0] address;
    logic [15:0] nexthop;
    logic [15:0] nextsinks;
    logic        done;

    logic [15:0] mem [0:2047];
    vec_t        vecs [NUM_VECS];
    int          testsRun;
    int          failCount;
    int          latency;

    find_best_hop dut (
        .clock     (clock),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .data_in   (data_in),
        .address   (address),
        .nexthop   (nexthop),
        .nextsinks (nextsinks),
        .done      (done)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Combinational memory: the value is ready one cycle before the DUT captures it.
    assign data_in = mem[address];

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic setEntry(input int v, input int i, input logic [15:0] id,
                            input logic [15:0] q, input logic [15:0] f);
        vecs[v].ids[i]   = id;
        vecs[v].qs[i]    = q;
        vecs[v].flags[i] = f;
    endtask

    task automatic setExpect(input int v, input logic [15:0] cnt, input logic [15:0] nh,
                             input logic [15:0] ns, input int lat, input logic [10:0] addr);
        vecs[v].count   = cnt;
        vecs[v].expNext = nh;
        vecs[v].expSink = ns;
        vecs[v].expLat  = lat;
        vecs[v].expAddr = addr;
    endtask

    task automatic loadMemory(input int v);
        for (int a = 0; a < 2048; a++) mem[a] = 16'd0;
        mem[COUNT_ADDR] = vecs[v].count;
        for (int i = 0; i < 16; i++) begin
            mem[ID_BASE + 11'(i)]   = vecs[v].ids[i];
            mem[Q_BASE + 11'(i)]    = vecs[v].qs[i];
            mem[SINK_BASE + 11'(i)] = vecs[v].flags[i];
        end
        // Entry 16 lies beyond the clamp and would win everything if ever scanned.
        mem[ID_BASE + 11'd16]   = 16'd99;
        mem[Q_BASE + 11'd16]    = 16'hFFFF;
        mem[SINK_BASE + 11'd16] = 16'd1;
    endtask

    task automatic pulseEn;
        @(negedge clock);
        en = 1'b1;
        @(posedge clock);
        #1 en = 1'b0;
    endtask

    // Returns edges from the start-sampling edge to the first edge with done high, or -1.
    task automatic pulseStartAndWait(output int lat);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        lat = -1;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = e;
                break;
            end
        end
        if (lat < 0) $display("[TB] FAIL timeout: done never rose, got %0d, expected 1", done);
    endtask

    task automatic applyStimulus(input int v, output int lat);
        loadMemory(v);
        pulseEn();
        pulseStartAndWait(lat);
    endtask

    // Stimulus table with hand-computed expectations, then ordered corner-case sequences.
    initial begin
        testsRun  = 0;
        failCount = 0;
        rst       = 1'b1;
        en        = 1'b0;
        start     = 1'b0;
        for (int a = 0; a < 2048; a++) mem[a] = 16'd0;
        for (int v = 0; v < NUM_VECS; v++) begin
            setExpect(v, 16'd0, 16'd65, 16'd65, 3, COUNT_ADDR);
            for (int i = 0; i < 16; i++) setEntry(v, i, 16'd0, 16'd0, 16'd0);
        end

        // Basic: best overall is 12, only sink is 30.
        setExpect(0, 16'd3, 16'd12, 16'd30, 21, 11'h062);
        setEntry(0, 0, 16'd7, 16'd100, 16'd0);
        setEntry(0, 1, 16'd12, 16'd250, 16'd0);
        setEntry(0, 2, 16'd30, 16'd180, 16'd1);
        // Empty table.
        setExpect(1, 16'd0, 16'd65, 16'd65, 3, COUNT_ADDR);
        // Equal Q: lower index wins for both outputs.
        setExpect(2, 16'd2, 16'd4, 16'd4, 15, 11'h061);
        setEntry(2, 0, 16'd4, 16'd50, 16'd1);
        setEntry(2, 1, 16'd9, 16'd50, 16'd1);
        // Count 40 clamped to 16; best at index 15 (ID 16), only sink at index 5 (ID 6).
        setExpect(3, 16'd40, 16'd16, 16'd6, 99, 11'h06F);
        for (int i = 0; i < 16; i++) setEntry(3, i, 16'(i + 1), 16'(i * 100), (i == 5) ? 16'd1 : 16'd0);
        // NONE_ID entry with huge Q is skipped.
        setExpect(4, 16'd2, 16'd3, 16'd65, 15, 11'h061);
        setEntry(4, 0, 16'd3, 16'd10, 16'd0);
        setEntry(4, 1, 16'd65, 16'hFFFF, 16'd0);
        // Q of zero is still accepted when nothing is held.
        setExpect(5, 16'd2, 16'd5, 16'd5, 15, 11'h061);
        setEntry(5, 0, 16'd5, 16'd0, 16'd1);
        setEntry(5, 1, 16'd8, 16'd0, 16'd0);
        // Sink choice independent of overall best.
        setExpect(6, 16'd3, 16'd1, 16'd3, 21, 11'h062);
        setEntry(6, 0, 16'd1, 16'd500, 16'd0);
        setEntry(6, 1, 16'd2, 16'd20, 16'd1);
        setEntry(6, 2, 16'd3, 16'd30, 16'd1);
        // Only entry is NONE_ID flagged as sink.
        setExpect(7, 16'd1, 16'd65, 16'd65, 9, 11'h060);
        setEntry(7, 0, 16'd65, 16'd7, 16'd1);

        #12;
        checkOutput("rstAddress", address, 0);
        checkOutput("rstNexthop", nexthop, 65);
        checkOutput("rstNextsinks", nextsinks, 65);
        checkOutput("rstDone", done, 0);
        @(negedge clock);
        rst = 1'b0;

        // Start before en is ignored while in WAIT.
        loadMemory(0);
        @(negedge clock);
        start = 1'b1;
        repeat (4) @(posedge clock);
        #1 start = 1'b0;
        checkOutput("startIgnoredAddr", address, 0);
        checkOutput("startIgnoredDone", done, 0);

        for (int v = 0; v < NUM_VECS; v++) begin
            applyStimulus(v, latency);
            checkOutput($sformatf("v%0d_latency", v), latency, vecs[v].expLat);
            checkOutput($sformatf("v%0d_nexthop", v), nexthop, vecs[v].expNext);
            checkOutput($sformatf("v%0d_nextsinks", v), nextsinks, vecs[v].expSink);
            checkOutput($sformatf("v%0d_lastAddr", v), address, vecs[v].expAddr);
        end

        // done and results hold in WAIT; start there is ignored.
        @(negedge clock);
        start = 1'b1;
        repeat (5) @(posedge clock);
        #1 start = 1'b0;
        checkOutput("doneHeld", done, 1);
        checkOutput("heldNexthop", nexthop, 65);
        checkOutput("heldAddr", address, 11'h060);

        // en clears results and returns to IDLE.
        pulseEn();
        checkOutput("rearmDone", done, 0);
        checkOutput("rearmAddr", address, 0);

        // Reset in the middle of entry 1's Q read aborts the scan.
        loadMemory(0);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (11) @(posedge clock);
        #1;
        checkOutput("preAbortNexthop", nexthop, 7);
        checkOutput("preAbortAddr", address, Q_BASE + 11'd1);
        rst = 1'b1;
        #1;
        checkOutput("abortAddr", address, 0);
        checkOutput("abortNexthop", nexthop, 65);
        checkOutput("abortNextsinks", nextsinks, 65);
        checkOutput("abortDone", done, 0);
        @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        start = 1'b1;
        repeat (3) @(posedge clock);
        #1 start = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        checkOutput("postAbortIgnoredDone", done, 0);
        checkOutput("postAbortIgnoredAddr", address, 0);
        applyStimulus(0, latency);
        checkOutput("rerunLatency", latency, 21);
        checkOutput("rerunNexthop", nexthop, 12);
        checkOutput("rerunNextsinks", nextsinks, 30);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
